vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the 640x480@60 timing generator. Samples external active-low hsync/vsync and recovers the pixel position (xpos/ypos) in the generator's coordinate system.
- Measures line period and lines per frame, and runs a lock state machine.
- Sits on the clk25 domain, ahead of any capture or overlay logic that needs pixel coordinates for an incoming video stream.

---
 rtl/vga_sync_decoder.sv | 175 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side 640x480 sync decoder: recovers xpos/ypos from external hsync/vsync,
// measures line/frame timing and tracks lock.
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned V_TOTAL    = 521,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned H_EDGE_X   = 659,
    parameter int unsigned V_EDGE_Y   = 490,
    parameter int unsigned LOCK_LINES = 4
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  xpos,
    output logic [9:0]  ypos,
    output logic        de,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines
);

    localparam int unsigned GW = $clog2(LOCK_LINES + 1);

    localparam logic [9:0]    X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    X_EDGE    = 10'(H_EDGE_X);
    localparam logic [9:0]    Y_EDGE    = 10'(V_EDGE_Y);
    localparam logic [9:0]    X_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]    Y_ACT     = 10'(V_ACTIVE);
    localparam logic [10:0]   P_LINE    = 11'(H_TOTAL);
    localparam logic [10:0]   P_TIMEOUT = 11'(2 * H_TOTAL);
    localparam logic [9:0]    F_LINES   = 10'(V_TOTAL);
    localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } state_t;

    state_t state, state_nx;

    logic hs_m, hs_s, hs_d;
    logic vs_m, vs_s, vs_d;
    logic hs_fall, vs_fall;

    logic [10:0]   pcnt;
    logic [9:0]    lcnt;
    logic [9:0]    lcnt_inc;
    logic [9:0]    fl_new;
    logic [GW-1:0] good, good_nx;
    logic          frame_valid, fvalid_nx;
    logic          x_wrap;
    logic          line_ok, frame_ok, judged, timeout;

    // Two-flop synchronizer plus one delay flop per sync; idle level is high
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            {hs_d, hs_s, hs_m} <= '1;
            {vs_d, vs_s, vs_m} <= '1;
        end else begin
            {hs_d, hs_s, hs_m} <= {hs_s, hs_m, hsync_in};
            {vs_d, vs_s, vs_m} <= {vs_s, vs_m, vsync_in};
        end
    end

    assign hs_fall = hs_d & ~hs_s;
    assign vs_fall = vs_d & ~vs_s;
    assign x_wrap  = (xpos == X_LAST);

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            xpos <= '0;
            ypos <= '0;
        end else begin
            if (hs_fall)     xpos <= X_EDGE;
            else if (x_wrap) xpos <= '0;
            else             xpos <= xpos + 10'd1;

            if (vs_fall)
                ypos <= Y_EDGE;
            else if (x_wrap && !hs_fall)
                ypos <= (ypos == Y_LAST) ? '0 : ypos + 10'd1;
        end
    end

    // Frame count includes an hsync fall landing on the same clock as vsync
    assign lcnt_inc = (lcnt == 10'h3FF) ? lcnt : lcnt + 10'd1;
    assign fl_new   = hs_fall ? lcnt_inc : lcnt;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            pcnt        <= '0;
            lcnt        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            if (hs_fall) begin
                pcnt     <= 11'd1;
                line_len <= pcnt;
            end else if (pcnt != 11'h7FF) begin
                pcnt <= pcnt + 11'd1;
            end

            if (vs_fall) begin
                frame_lines <= fl_new;
                lcnt        <= hs_fall ? 10'd1 : '0;
            end else if (hs_fall) begin
                lcnt <= lcnt_inc;
            end
        end
    end

    assign line_ok  = (pcnt == P_LINE);
    assign frame_ok = (fl_new == F_LINES);
    assign judged   = vs_fall && frame_valid;
    assign timeout  = (pcnt >= P_TIMEOUT);

    always_comb begin
        state_nx  = state;
        good_nx   = good;
        fvalid_nx = frame_valid;
        case (state)
            SEARCH: begin
                if (hs_fall) begin
                    state_nx  = TRACK;
                    good_nx   = '0;
                    fvalid_nx = 1'b0;
                end
            end
            TRACK: begin
                if (hs_fall)
                    good_nx = !line_ok ? '0 : (good == GOOD_MAX) ? good : good + GW'(1);
                if (judged && !frame_ok)
                    good_nx = '0;
                if (vs_fall)
                    fvalid_nx = 1'b1;
                if (timeout)
                    state_nx = SEARCH;
                else if (judged && frame_ok && good == GOOD_MAX)
                    state_nx = LOCKED;
            end
            LOCKED: begin
                if (vs_fall)
                    fvalid_nx = 1'b1;
                if (timeout || (hs_fall && !line_ok) || (judged && !frame_ok))
                    state_nx = SEARCH;
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            good        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            good        <= good_nx;
            frame_valid <= fvalid_nx;
            sync_err    <= (state == LOCKED) && (state_nx == SEARCH);
        end
    end

    assign locked      = (state == LOCKED);
    assign de          = locked && (xpos < X_ACT) && (ypos < Y_ACT);
    assign frame_start = locked && (xpos == '0) && (ypos == '0);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a scaled-down raster (40x12 clocks/lines) so
// several lock/unlock cycles fit in a short run.
module tb_vga_sync_decoder;

    localparam int HT  = 40;
    localparam int VT  = 12;
    localparam int HA  = 32;
    localparam int VA  = 8;
    localparam int HEX = 37;
    localparam int VEY = 9;
    localparam int LL  = 4;
    localparam int HS_LO = HEX - 4;
    localparam int HS_HI = HEX - 1;

    localparam int EV_LOCK = 0;
    localparam int EV_SERR = 1;

    typedef struct {
        int kind;
        int fl;
        int ll;
        int gx;
    } ev_t;

    logic        clk25 = 1'b0;
    logic        rst_n;
    logic        hsync_in, vsync_in;
    logic [9:0]  xpos, ypos;
    logic        de, locked, frame_start, sync_err;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;

    int   gx, gy;
    logic gen_hs, gen_vs;
    logic gen_restart, hs_kill, use_gen;
    logic man_hs, man_vs;
    int   gen_htot, gen_vtot;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    ev_t  sbq[$];

    assign hsync_in = use_gen ? gen_hs : man_hs;
    assign vsync_in = use_gen ? gen_vs : man_vs;

    vga_sync_decoder #(
        .H_TOTAL   (HT),
        .V_TOTAL   (VT),
        .H_ACTIVE  (HA),
        .V_ACTIVE  (VA),
        .H_EDGE_X  (HEX),
        .V_EDGE_Y  (VEY),
        .LOCK_LINES(LL)
    ) dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .de         (de),
        .locked     (locked),
        .frame_start(frame_start),
        .sync_err   (sync_err),
        .line_len   (line_len),
        .frame_lines(frame_lines)
    );

    always #20 clk25 = ~clk25;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int fl, input int ll, input int x);
        ev_t e;
        e.kind = kind; e.fl = fl; e.ll = ll; e.gx = x;
        sbq.push_back(e);
    endtask

    task automatic wait_gen(input int x, input int y, input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk25);
        while (!(gx == x && (y < 0 || gy == y)) && n < budget) begin
            @(negedge clk25);
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_%s: generator position not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk25);
            n++;
        end
        check({"drain_", name}, sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk25);
        rst_n = 1'b0;
        gen_restart = 1'b1;
        repeat (3) @(negedge clk25);
        rst_n = 1'b1;
        gen_restart = 1'b0;
    endtask

    task automatic man_hs_pulse();
        @(posedge clk25); #1 man_hs = 1'b0;
        repeat (4) @(posedge clk25);
        #1 man_hs = 1'b1;
        repeat (8) @(posedge clk25);
    endtask

    // Registered-output sync generator: pins follow the previous counter value
    initial begin
        gx = 0; gy = 0; gen_hs = 1'b1; gen_vs = 1'b1;
        forever begin
            @(posedge clk25);
            #1;
            if (gen_restart) begin
                gx = 0; gy = 0; gen_hs = 1'b1; gen_vs = 1'b1;
            end else begin
                gen_hs = hs_kill || !(gx >= HS_LO && gx <= HS_HI);
                gen_vs = !(gy >= VEY && gy <= VEY + 1);
                if (gx == gen_htot - 1) begin
                    gx = 0;
                    gy = (gy == gen_vtot - 1) ? 0 : gy + 1;
                end else begin
                    gx = gx + 1;
                end
            end
        end
    end

    // Monitor: compares scoreboard entries when the DUT signals lock or a sync error
    initial begin
        logic locked_q, serr_q;
        int   last_fs;
        ev_t  e;
        locked_q = 1'b0; serr_q = 1'b0; last_fs = -1;
        forever begin
            @(negedge clk25);
            cyc++;
            if (locked && !locked_q) begin
                if (sbq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_lock: got locked rise, expected none (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    check("lock_kind", EV_LOCK, e.kind);
                    check("lock_frame_lines", int'(frame_lines), e.fl);
                    check("lock_line_len", int'(line_len), e.ll);
                    check("lock_gx", gx, e.gx);
                end
            end
            if (sync_err) begin
                if (sbq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_sync_err: got pulse, expected none (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    check("serr_kind", EV_SERR, e.kind);
                    check("serr_locked", int'(locked), 0);
                    if (e.fl >= 0) check("serr_frame_lines", int'(frame_lines), e.fl);
                    if (e.gx >= 0) check("serr_gx", gx, e.gx);
                end
            end
            if (serr_q) check("sync_err_width", int'(sync_err), 0);
            if (frame_start) begin
                check("fs_xpos", int'(xpos), 0);
                check("fs_ypos", int'(ypos), 0);
                if (last_fs >= 0) check("fs_gap", cyc - last_fs, HT * VT);
                last_fs = cyc;
            end
            if (!locked) last_fs = -1;
            locked_q = locked;
            serr_q   = sync_err;
        end
    end

    initial begin
        #(60000 * 40);
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int dec, mm, lk;
        rst_n = 1'b0; use_gen = 1'b1; gen_restart = 1'b1; hs_kill = 1'b0;
        man_hs = 1'b1; man_vs = 1'b1; gen_htot = HT; gen_vtot = VT;

        @(negedge clk25);
        check("rst_xpos", int'(xpos), 0);
        check("rst_ypos", int'(ypos), 0);
        check("rst_de", int'(de), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_sync_err", int'(sync_err), 0);
        check("rst_line_len", int'(line_len), 0);
        check("rst_frame_lines", int'(frame_lines), 0);
        repeat (2) @(negedge clk25);
        rst_n = 1'b1;
        gen_restart = 1'b0;

        // Nominal acquisition: lock one clock after the second vsync fall
        push_ev(EV_LOCK, VT, HT, 4);
        wait_drain(1500, "nominal_lock");

        wait_gen(0, 0, 600, "frame0");
        dec = 0; mm = 0;
        for (int i = 0; i < HT * VT; i++) begin
            if (de) dec++;
            if (int'(xpos) != gx || int'(ypos) != gy) mm++;
            @(negedge clk25);
        end
        check("de_cycles_per_frame", dec, HA * VA);
        check("pos_mismatch_cycles", mm, 0);

        // Hold hsync high: timeout two lines on, then pcnt saturates
        wait_gen(0, 0, 600, "hold_start");
        hs_kill = 1'b1;
        push_ev(EV_SERR, VT, -1, HEX);
        wait_drain(200, "hold_timeout");
        check("hold_locked", int'(locked), 0);
        repeat (2100) @(negedge clk25);
        wait_gen(0, -1, 100, "hold_end");
        hs_kill = 1'b0;
        push_ev(EV_LOCK, VT, HT, 4);
        wait_gen(HEX, -1, 100, "first_hs_after_hold");
        check("line_len_saturated", int'(line_len), 2047);
        check("xpos_reload", int'(xpos), HEX);
        wait_drain(2000, "relock_after_hold");

        // One short frame while locked
        wait_gen(10, VEY, 600, "short_set");
        gen_vtot = VT - 1;
        push_ev(EV_SERR, VT - 1, -1, 4);
        push_ev(EV_LOCK, VT, HT, 4);
        wait_gen(0, 0, 600, "short_clear");
        gen_vtot = VT;
        wait_drain(2500, "short_frame");

        // Asynchronous reset mid-line while locked
        wait_gen(10, 2, 600, "mid_reset");
        check("pre_reset_locked", int'(locked), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_locked", int'(locked), 0);
        check("async_rst_de", int'(de), 0);
        check("async_rst_xpos", int'(xpos), 0);
        check("async_rst_ypos", int'(ypos), 0);
        check("async_rst_line_len", int'(line_len), 0);
        check("async_rst_frame_lines", int'(frame_lines), 0);
        repeat (5) @(negedge clk25);
        rst_n = 1'b1;
        push_ev(EV_LOCK, VT, HT, 4);
        dec = 0;
        for (int i = 0; i < 2000 && !locked; i++) begin
            if (de) dec++;
            @(negedge clk25);
        end
        check("de_before_relock", dec, 0);
        wait_drain(10, "relock_after_reset");
        check("relock_xpos_aligned", int'(xpos), gx);

        // Line one clock too long: never locks
        gen_htot = HT + 1;
        do_reset();
        lk = 0;
        for (int i = 0; i < (HT + 1) * VT * 4; i++) begin
            if (locked) lk++;
            @(negedge clk25);
        end
        check("long_line_locked_cycles", lk, 0);
        check("long_line_len", int'(line_len), HT + 1);
        check("long_frame_lines", int'(frame_lines), VT);

        // Simultaneous hsync and vsync fall, driven by hand
        gen_htot = HT;
        use_gen = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) man_hs_pulse();
        @(posedge clk25);
        #1;
        man_hs = 1'b0;
        man_vs = 1'b0;
        repeat (3) @(posedge clk25);
        @(negedge clk25);
        check("aligned_xpos", int'(xpos), HEX);
        check("aligned_ypos", int'(ypos), VEY);
        check("aligned_frame_lines", int'(frame_lines), 4);
        check("aligned_line_len", int'(line_len), 13);
        check("aligned_locked", int'(locked), 0);
        repeat (5) @(negedge clk25);

        check("sb_leftover", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
